// File: rtl/rtc_calendar_if.sv
// rtc_calendar_if: host-side register bus of the calendar clock
interface rtc_calendar_if #(
    parameter int unsigned DATA_W = 64
);
    logic              ren;
    logic [DATA_W-1:0] rdata;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic              alarm_wen;
    logic [DATA_W-1:0] alarm_data;
    logic              alarm_en;
    logic              irq_clr;
    logic              irq;
    logic              wr_err;
    modport master (
        output ren, wen, wdata, alarm_wen, alarm_data, alarm_en, irq_clr,
        input  rdata, irq, wr_err
    );
    modport slave (
        input  ren, wen, wdata, alarm_wen, alarm_data, alarm_en, irq_clr,
        output rdata, irq, wr_err
    );
endinterface

// File: rtl/rtc_calendar.sv
// rtc_calendar: second-resolution calendar clock with validated writes and a sticky alarm interrupt
module rtc_calendar #(
    parameter int unsigned CLK_PER_SEC = 100,
    parameter int unsigned DATA_W      = 64
) (
    input logic           clk,
    input logic           rst,
    rtc_calendar_if.slave bus
);
    localparam logic [42:0] RST_CAL   = {16'd2021, 4'd1, 5'd2, 6'd3, 6'd4, 6'd5};
    localparam logic [31:0] PRESC_MAX = 32'(CLK_PER_SEC - 1);

    function automatic logic is_leap(input logic [15:0] y);
        return (y[1:0] == 2'd0) && (((y % 16'd100) != 16'd0) || ((y % 16'd400) == 16'd0));
    endfunction

    function automatic logic [4:0] month_days(input logic [3:0] m, input logic [15:0] y);
        return (m == 4'd2) ? (is_leap(y) ? 5'd29 : 5'd28)
             : (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    function automatic logic valid_cal(input logic [42:0] c);
        return (c[5:0] < 6'd60) && (c[11:6] < 6'd60) && (c[17:12] < 6'd24)
            && (c[26:23] >= 4'd1) && (c[26:23] <= 4'd12)
            && (c[22:18] >= 5'd1) && (c[22:18] <= month_days(c[26:23], c[42:27]))
            && (c[42:27] <= 16'd9999);
    endfunction

    // Full one-second advance; every carried field is produced together.
    function automatic logic [42:0] cal_inc(input logic [42:0] c);
        logic [15:0] y;
        logic [3:0]  mo;
        logic [4:0]  d;
        logic [5:0]  h, mi, s;
        {y, mo, d, h, mi, s} = c;
        if (s != 6'd59) s = s + 6'd1;
        else begin
            s = 6'd0;
            if (mi != 6'd59) mi = mi + 6'd1;
            else begin
                mi = 6'd0;
                if (h != 6'd23) h = h + 6'd1;
                else begin
                    h = 6'd0;
                    if (d != month_days(mo, y)) d = d + 5'd1;
                    else begin
                        d = 5'd1;
                        if (mo != 4'd12) mo = mo + 4'd1;
                        else begin
                            mo = 4'd1;
                            y  = (y == 16'd9999) ? 16'd0 : y + 16'd1;
                        end
                    end
                end
            end
        end
        return {y, mo, d, h, mi, s};
    endfunction

    logic [31:0] presc_q, presc_d;
    logic [42:0] cal_q, cal_d, alarm_q, alarm_d, cal_next;
    logic        irq_q, irq_d, wr_err_q, wr_err_d;
    logic        tick, w_ok, a_ok, set_irq;
    logic        unused_bits;

    // Next-state: a valid time write beats the tick; only a tick-driven advance can raise the alarm.
    always_comb begin
        tick     = presc_q == PRESC_MAX;
        cal_next = cal_inc(cal_q);
        w_ok     = bus.wen && valid_cal(bus.wdata[42:0]);
        a_ok     = bus.alarm_wen && valid_cal(bus.alarm_data[42:0]);
        set_irq  = tick && !w_ok && bus.alarm_en && (cal_next == alarm_q);
        presc_d  = (w_ok || tick) ? 32'd0 : presc_q + 32'd1;
        cal_d    = w_ok ? bus.wdata[42:0] : tick ? cal_next : cal_q;
        alarm_d  = a_ok ? bus.alarm_data[42:0] : alarm_q;
        irq_d    = set_irq || (irq_q && !bus.irq_clr);
        wr_err_d = (bus.wen && !w_ok) || (bus.alarm_wen && !a_ok);
    end

    // State registers; reset overrides every strobe and the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            cal_q    <= RST_CAL;
            alarm_q  <= '0;
            irq_q    <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            cal_q    <= cal_d;
            alarm_q  <= alarm_d;
            irq_q    <= irq_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.rdata   = (rst || !bus.ren) ? '0 : DATA_W'(cal_q);
    assign bus.irq     = irq_q;
    assign bus.wr_err  = wr_err_q;
    assign unused_bits = ^{bus.wdata, bus.alarm_data};
endmodule

// File: doc/rtc_calendar.md
RTC_CALENDAR -- requirements
Module: rtc_calendar

Interface
REQ-001 Parameter CLK_PER_SEC, default 100: clk cycles per second tick; legal range 1 .. 2^32-1.
REQ-002 Parameter DATA_W, default 64: width of rdata/wdata/alarm_data; minimum 43; bits [DATA_W-1:43] read 0 and are ignored on write.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 ren  input  1  read enable.
REQ-006 rdata  output  DATA_W  packed calendar: second[5:0], minute[11:6], hour[17:12], day[22:18], month[26:23], year[42:27].
REQ-007 wen  input  1  time-set strobe.
REQ-008 wdata  input  DATA_W  time to load, same packing as rdata.
REQ-009 alarm_wen  input  1  alarm-register load strobe.
REQ-010 alarm_data  input  DATA_W  alarm value, same packing.
REQ-011 alarm_en  input  1  alarm compare enable (level).
REQ-012 irq_clr  input  1  clears irq.
REQ-013 irq  output  1  sticky alarm interrupt.
REQ-014 wr_err  output  1  one-cycle pulse: rejected time or alarm write.

Function
REQ-015 Prescaler counts 0..CLK_PER_SEC-1; tick asserts in the cycle it equals CLK_PER_SEC-1, then wraps to 0; CLK_PER_SEC=1 gives a tick every cycle.
REQ-016 On tick: second increments 0..59; 59->0 carries to minute (0..59), then hour (0..23), then day, then month (1..12), then year (0..9999; 9999->0).
REQ-017 Day range 1..N: N=31 for months 1,3,5,7,8,10,12; N=30 for 4,6,9,11; N=28 for February, 29 in leap years.
REQ-018 Leap year: year divisible by 4 and (not by 100, or by 400); year 0 is leap.
REQ-019 A carry updates all affected fields in the same clock edge; no intermediate value is visible on rdata.
REQ-020 wen with valid wdata loads all six fields and clears the prescaler at the next edge; valid means each field is within its range, with day checked against the written month/year.
REQ-021 Valid wen coincident with tick: the write wins and that tick is discarded.
REQ-022 Invalid wen: calendar and prescaler unchanged; wr_err pulses high in the following cycle.
REQ-023 alarm_wen loads the alarm register under the same validity rule; an invalid alarm write also pulses wr_err; simultaneous wen and alarm_wen are both processed independently.
REQ-024 Match: irq is set at the edge on which the calendar, advanced by a tick, becomes equal to the full 43-bit alarm value while alarm_en=1; a calendar change caused by wen never sets irq.
REQ-025 irq stays high until irq_clr; if set and irq_clr occur in the same cycle, set wins.
REQ-026 rdata is combinational: rdata = 0 when rst=1 or ren=0, otherwise the current packed calendar; a write appears on rdata the cycle after the write edge.

Reset
REQ-027 While rst=1: calendar = 2021-01-02 03:04:05, prescaler 0, alarm register 0, irq 0, wr_err 0, rdata 0.
REQ-028 rst overrides wen, alarm_wen, irq_clr and tick in the same cycle, including mid-count and mid-carry.

Verification (CLK_PER_SEC=4)
REQ-029 Release reset, ren=1 -> rdata fields 2021/1/2 03:04:05; after 4 clocks seconds = 6; after 60 further ticks minutes = 5.
REQ-030 Write 2023-12-31 23:59:59, wait 1 tick -> 2024-01-01 00:00:00 in a single edge.
REQ-031 Write 2024-02-28 23:59:59, then after 1 tick -> 2024-02-29 00:00:00. Write 2100-02-28 23:59:59, then after 1 tick -> 2100-03-01. Write 2000-02-28 23:59:59, then after 1 tick -> 2000-02-29.
REQ-032 Write 2023-02-29 or hour=24 -> calendar unchanged; wr_err high for exactly one cycle.
REQ-033 Alarm 2021-01-02 03:04:07 with alarm_en=1 -> irq rises 8 clocks after reset release; it holds through irq_clr asserted in the same cycle as the set; it falls one edge after irq_clr is asserted alone.
REQ-034 Assert wen on the tick cycle, then assert rst with the prescaler at 2 -> write wins with the prescaler reset to 0; rst restores the reset values on the next edge.
